// File: rtl/dma_burst_sequencer.sv
// Splits one DMA transfer into matched AXI read/write bursts (<=MAX_BEATS, no 4 KiB crossing); optional DMA_SEQ_PERF_EN busy-cycle counter.
// Latency: start -> first command 2 cycles (CALC, ISSUE); one CALC cycle between consecutive bursts.
// Backpressure: commands hold until each side handshakes; CALC stalls at MAX_OUTSTANDING uncompleted bursts.

module dma_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          srst_i,
    input  logic          push_i,
    input  logic [W-1:0]  dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  dat_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dat_o   = r_mem[r_rd_ptr];
    assign count_o = r_count;
endmodule

module dma_burst_sequencer #(
    parameter int ADDR_W          = 64,
    parameter int SIZE_W          = 32,
    parameter int DATA_BYTES      = 4,
    parameter int MAX_BEATS       = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic              int_en_i,
    input  logic              abort_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    output logic              busy_o,
    output logic [SIZE_W-1:0] rem_o,
    output logic              done_o,
    output logic              err_o,
    output logic              irq_o,
    input  logic              irq_clr_i,
    output logic              rd_cmd_valid_o,
    input  logic              rd_cmd_ready_i,
    output logic [ADDR_W-1:0] rd_cmd_addr_o,
    output logic [7:0]        rd_cmd_len_o,
    output logic              wr_cmd_valid_o,
    input  logic              wr_cmd_ready_i,
    output logic [ADDR_W-1:0] wr_cmd_addr_o,
    output logic [7:0]        wr_cmd_len_o,
    input  logic              wr_done_i,
    input  logic [1:0]        wr_resp_i,
    output logic [31:0]       perf_cycles_o
);
    localparam int SHIFT = $clog2(DATA_BYTES);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [SIZE_W-1:0] r_rem_issue;
    logic [SIZE_W-1:0] r_rem;
    logic [7:0]        r_len;
    logic              r_rd_done;
    logic              r_wr_done;
    logic              r_busy;
    logic              r_err;
    logic              r_irq;
    logic              r_abort;

    logic              w_start;
    logic              w_misaligned;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_push;
    logic              w_pop;
    logic              w_err_in;
    logic              w_stop;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic [7:0]        w_fifo_dat;
    logic [12:0]       w_src_beats;
    logic [12:0]       w_dst_beats;
    logic [SIZE_W-1:0] w_rem_beats;
    logic [8:0]        w_beats;
    logic [SIZE_W-1:0] w_burst_bytes;
    logic [SIZE_W-1:0] w_pop_bytes;
    logic [SIZE_W-1:0] w_rem_issue_nxt;

    assign w_start      = (r_state == S_IDLE) && start_i;
    assign w_misaligned = (|(src_addr_i & ADDR_W'(DATA_BYTES - 1)))
                        | (|(dst_addr_i & ADDR_W'(DATA_BYTES - 1)))
                        | (|(size_i & SIZE_W'(DATA_BYTES - 1)));

    assign rd_cmd_valid_o = (r_state == S_ISSUE) && !r_rd_done;
    assign wr_cmd_valid_o = (r_state == S_ISSUE) && !r_wr_done;
    assign w_rd_ok        = r_rd_done || (rd_cmd_valid_o && rd_cmd_ready_i);
    assign w_wr_ok        = r_wr_done || (wr_cmd_valid_o && wr_cmd_ready_i);
    assign w_push         = (r_state == S_ISSUE) && w_rd_ok && w_wr_ok;

    // A completion with nothing outstanding is a protocol error, not a pop.
    assign w_pop    = wr_done_i && (w_count != '0);
    assign w_err_in = wr_done_i && ((wr_resp_i != 2'b00) || (w_count == '0));
    assign w_stop   = r_abort || abort_i || r_err || w_err_in;
    assign w_full   = (w_count == CNT_W'(MAX_OUTSTANDING));

    dma_seq_fifo #(
        .W     (8),
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CNT_W)
    ) u_len_fifo (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .push_i  (w_push),
        .dat_i   (r_len),
        .pop_i   (w_pop),
        .dat_o   (w_fifo_dat),
        .count_o (w_count)
    );

    // Room to the next 4 KiB page is 1..4096 bytes, so 13 bits always suffice.
    assign w_src_beats = (13'h1000 - {1'b0, r_src[11:0]}) >> SHIFT;
    assign w_dst_beats = (13'h1000 - {1'b0, r_dst[11:0]}) >> SHIFT;
    assign w_rem_beats = r_rem_issue >> SHIFT;

    always_comb begin
        w_beats = 9'(MAX_BEATS);
        if (w_rem_beats < SIZE_W'(w_beats)) begin
            w_beats = w_rem_beats[8:0];
        end
        if (w_src_beats < 13'(w_beats)) begin
            w_beats = w_src_beats[8:0];
        end
        if (w_dst_beats < 13'(w_beats)) begin
            w_beats = w_dst_beats[8:0];
        end
    end

    assign w_burst_bytes   = (SIZE_W'(r_len) + SIZE_W'(1)) << SHIFT;
    assign w_pop_bytes     = (SIZE_W'(w_fifo_dat) + SIZE_W'(1)) << SHIFT;
    assign w_rem_issue_nxt = r_rem_issue - w_burst_bytes;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (w_misaligned || (size_i == '0)) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_stop) begin
                    w_state_nxt = S_DRAIN;
                end else if (!w_full) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_rd_ok && w_wr_ok) begin
                    w_state_nxt = ((w_rem_issue_nxt == '0) || w_stop) ? S_DRAIN : S_CALC;
                end
            end
            S_DRAIN: begin
                if (w_count == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_rem_issue <= '0;
            r_rem       <= '0;
            r_len       <= '0;
            r_rd_done   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_irq       <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            if (w_start) begin
                r_src       <= src_addr_i;
                r_dst       <= dst_addr_i;
                r_rem_issue <= size_i;
                r_rem       <= size_i;
                r_err       <= w_misaligned;
                r_abort     <= 1'b0;
                r_busy      <= 1'b1;
            end else begin
                if (w_pop) begin
                    r_rem <= r_rem - w_pop_bytes;
                end
                if (w_err_in) begin
                    r_err <= 1'b1;
                end
                if (abort_i && r_busy) begin
                    r_abort <= 1'b1;
                end
            end

            if (r_state == S_CALC) begin
                r_len     <= 8'(w_beats - 9'd1);
                r_rd_done <= 1'b0;
                r_wr_done <= 1'b0;
            end

            if (r_state == S_ISSUE) begin
                if (rd_cmd_valid_o && rd_cmd_ready_i) begin
                    r_rd_done <= 1'b1;
                end
                if (wr_cmd_valid_o && wr_cmd_ready_i) begin
                    r_wr_done <= 1'b1;
                end
                if (w_push) begin
                    r_src       <= r_src + ADDR_W'(w_burst_bytes);
                    r_dst       <= r_dst + ADDR_W'(w_burst_bytes);
                    r_rem_issue <= w_rem_issue_nxt;
                end
            end

            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
            end

            // A new interrupt outranks a clear arriving in the same cycle.
            if ((r_state == S_DONE) && int_en_i) begin
                r_irq <= 1'b1;
            end else if (irq_clr_i) begin
                r_irq <= 1'b0;
            end
        end
    end

`ifdef DMA_SEQ_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_perf <= '0;
        end else if (w_start) begin
            r_perf <= '0;
        end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles_o = r_perf;
`else
    assign perf_cycles_o = 32'd0;
`endif

    assign busy_o        = r_busy;
    assign rem_o         = r_rem;
    assign done_o        = (r_state == S_DONE);
    assign err_o         = r_err;
    assign irq_o         = r_irq;
    assign rd_cmd_addr_o = r_src;
    assign rd_cmd_len_o  = r_len;
    assign wr_cmd_addr_o = r_dst;
    assign wr_cmd_len_o  = r_len;
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Directed bench for dma_burst_sequencer (DATA_BYTES=4, MAX_BEATS=256, MAX_OUTSTANDING=2).
// Logs command handshakes, optionally auto-completes write bursts, and compares against hand-computed values.

module tb_dma_burst_sequencer;
    logic        clk_i = 1'b0;
    logic        srst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        int_en_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] size_i = '0;
    logic [63:0] src_addr_i = '0;
    logic [63:0] dst_addr_i = '0;
    logic        busy_o;
    logic [31:0] rem_o;
    logic        done_o;
    logic        err_o;
    logic        irq_o;
    logic        irq_clr_i = 1'b0;
    logic        rd_cmd_valid_o;
    logic        rd_cmd_ready_i = 1'b1;
    logic [63:0] rd_cmd_addr_o;
    logic [7:0]  rd_cmd_len_o;
    logic        wr_cmd_valid_o;
    logic        wr_cmd_ready_i = 1'b1;
    logic [63:0] wr_cmd_addr_o;
    logic [7:0]  wr_cmd_len_o;
    logic        wr_done_i = 1'b0;
    logic [1:0]  wr_resp_i = 2'b00;
    logic [31:0] perf_cycles_o;

    int          n_chk = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          pending = 0;
    bit          auto_done = 1'b0;
    logic [63:0] rd_addr_q[$];
    logic [7:0]  rd_len_q[$];
    logic [63:0] wr_addr_q[$];
    logic [7:0]  wr_len_q[$];

    always #5 clk_i = ~clk_i;

    dma_burst_sequencer #(
        .ADDR_W          (64),
        .SIZE_W          (32),
        .DATA_BYTES      (4),
        .MAX_BEATS       (256),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .start_i        (start_i),
        .int_en_i       (int_en_i),
        .abort_i        (abort_i),
        .size_i         (size_i),
        .src_addr_i     (src_addr_i),
        .dst_addr_i     (dst_addr_i),
        .busy_o         (busy_o),
        .rem_o          (rem_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .irq_o          (irq_o),
        .irq_clr_i      (irq_clr_i),
        .rd_cmd_valid_o (rd_cmd_valid_o),
        .rd_cmd_ready_i (rd_cmd_ready_i),
        .rd_cmd_addr_o  (rd_cmd_addr_o),
        .rd_cmd_len_o   (rd_cmd_len_o),
        .wr_cmd_valid_o (wr_cmd_valid_o),
        .wr_cmd_ready_i (wr_cmd_ready_i),
        .wr_cmd_addr_o  (wr_cmd_addr_o),
        .wr_cmd_len_o   (wr_cmd_len_o),
        .wr_done_i      (wr_done_i),
        .wr_resp_i      (wr_resp_i),
        .perf_cycles_o  (perf_cycles_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are final for the coming edge here; log what that edge will accept.
    task automatic cyc();
        if (auto_done) begin
            wr_done_i = (pending > 0);
            if (wr_done_i) pending--;
        end
        if (rd_cmd_valid_o && rd_cmd_ready_i) begin
            rd_addr_q.push_back(rd_cmd_addr_o);
            rd_len_q.push_back(rd_cmd_len_o);
        end
        if (wr_cmd_valid_o && wr_cmd_ready_i) begin
            wr_addr_q.push_back(wr_cmd_addr_o);
            wr_len_q.push_back(wr_cmd_len_o);
            if (auto_done) pending++;
        end
        if (done_o) n_done++;
        @(posedge clk_i);
        #1;
        start_i   = 1'b0;
        wr_done_i = 1'b0;
        irq_clr_i = 1'b0;
        abort_i   = 1'b0;
    endtask

    task automatic start_xfer(input logic [63:0] src, input logic [63:0] dst, input logic [31:0] size);
        rd_addr_q.delete();
        rd_len_q.delete();
        wr_addr_q.delete();
        wr_len_q.delete();
        n_done     = 0;
        src_addr_i = src;
        dst_addr_i = dst;
        size_i     = size;
        start_i    = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) cyc();
        chk(tag, 64'(n_done), 64'd1);
    endtask

    initial begin
        repeat (3) cyc();
        srst_i = 1'b0;
        cyc();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rem", 64'(rem_o), 64'd0);
        chk("rst_rd_valid", 64'(rd_cmd_valid_o), 64'd0);
        chk("rst_wr_valid", 64'(wr_cmd_valid_o), 64'd0);
        chk("rst_err_irq_done", {61'd0, err_o, irq_o, done_o}, 64'd0);

        // Single 16-beat burst.
        auto_done = 1'b1;
        pending   = 0;
        start_xfer(64'h1000, 64'h2000, 32'h40);
        chk("t1_busy", 64'(busy_o), 64'd1);
        chk("t1_rem_load", 64'(rem_o), 64'h40);
        wait_done("t1_done", 40);
        chk("t1_rd_n", 64'(rd_addr_q.size()), 64'd1);
        chk("t1_rd_addr", rd_addr_q[0], 64'h1000);
        chk("t1_rd_len", 64'(rd_len_q[0]), 64'd15);
        chk("t1_wr_addr", wr_addr_q[0], 64'h2000);
        chk("t1_wr_len", 64'(wr_len_q[0]), 64'd15);
        chk("t1_rem", 64'(rem_o), 64'd0);
        chk("t1_busy_end", 64'(busy_o), 64'd0);
        chk("t1_err", 64'(err_o), 64'd0);
`ifdef DMA_SEQ_PERF_EN
        chk("t1_perf", 64'(perf_cycles_o), 64'd5);
`else
        chk("t1_perf", 64'(perf_cycles_o), 64'd0);
`endif

        // Source crosses a 4 KiB page after 16 bytes.
        start_xfer(64'h0FF0, 64'h3000, 32'h20);
        wait_done("t2_done", 40);
        chk("t2_rd_n", 64'(rd_addr_q.size()), 64'd2);
        chk("t2_rd_addr0", rd_addr_q[0], 64'h0FF0);
        chk("t2_rd_len0", 64'(rd_len_q[0]), 64'd3);
        chk("t2_wr_addr0", wr_addr_q[0], 64'h3000);
        chk("t2_rd_addr1", rd_addr_q[1], 64'h1000);
        chk("t2_rd_len1", 64'(rd_len_q[1]), 64'd3);
        chk("t2_wr_addr1", wr_addr_q[1], 64'h3010);
        chk("t2_rem", 64'(rem_o), 64'd0);

        // MAX_BEATS split of a full page.
        start_xfer(64'h0, 64'h0, 32'h1000);
        wait_done("t3_done", 100);
        chk("t3_rd_n", 64'(rd_addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rd_addr%0d", i), rd_addr_q[i], 64'(i * 32'h400));
            chk($sformatf("t3_len%0d", i), 64'(rd_len_q[i]), 64'd255);
        end

        // Outstanding limit with completions withheld.
        auto_done = 1'b0;
        start_xfer(64'h0, 64'h8000, 32'h1000);
        repeat (30) cyc();
        chk("t4_rd_n_held", 64'(rd_addr_q.size()), 64'd2);
        chk("t4_wr_n_held", 64'(wr_addr_q.size()), 64'd2);
        chk("t4_rd_valid_held", 64'(rd_cmd_valid_o), 64'd0);
        chk("t4_busy_held", 64'(busy_o), 64'd1);
        wr_done_i = 1'b1;
        cyc();
        repeat (6) cyc();
        chk("t4_rd_n_third", 64'(rd_addr_q.size()), 64'd3);
        chk("t4_rd_addr2", rd_addr_q[2], 64'h800);
        chk("t4_wr_addr2", wr_addr_q[2], 64'h8800);
        pending   = wr_addr_q.size() - 1;
        auto_done = 1'b1;
        wait_done("t4_done", 100);
        chk("t4_rd_n", 64'(rd_addr_q.size()), 64'd4);
        chk("t4_rem", 64'(rem_o), 64'd0);

        // Error response on the first completion.
        auto_done = 1'b0;
        pending   = 0;
        int_en_i  = 1'b1;
        start_xfer(64'h0, 64'h0, 32'h800);
        for (int i = 0; i < 20 && wr_addr_q.size() == 0; i++) cyc();
        wr_done_i = 1'b1;
        wr_resp_i = 2'b10;
        cyc();
        wr_resp_i = 2'b00;
        wait_done("t5_done", 40);
        chk("t5_err", 64'(err_o), 64'd1);
        chk("t5_rd_n", 64'(rd_addr_q.size()), 64'd1);
        chk("t5_irq", 64'(irq_o), 64'd1);
        chk("t5_rem", 64'(rem_o), 64'h400);
        irq_clr_i = 1'b1;
        cyc();
        chk("t5_irq_clr", 64'(irq_o), 64'd0);
        chk("t5_err_sticky", 64'(err_o), 64'd1);
        int_en_i = 1'b0;

        // Abort before the first burst is issued.
        auto_done = 1'b1;
        start_xfer(64'h0, 64'h0, 32'h1000);
        chk("ab_err_cleared", 64'(err_o), 64'd0);
        abort_i = 1'b1;
        wait_done("ab_done", 40);
        chk("ab_rd_n", 64'(rd_addr_q.size()), 64'd0);
        chk("ab_rem", 64'(rem_o), 64'h1000);

        // Misaligned source.
        start_xfer(64'h1002, 64'h0, 32'h10);
        wait_done("t6_done", 20);
        chk("t6_err", 64'(err_o), 64'd1);
        chk("t6_rd_n", 64'(rd_addr_q.size()), 64'd0);
        chk("t6_rem", 64'(rem_o), 64'h10);
        chk("t6_irq", 64'(irq_o), 64'd0);

        // Reset in ISSUE abandons the transfer.
        auto_done = 1'b0;
        start_xfer(64'h0, 64'h0, 32'h1000);
        chk("t6r_err_cleared", 64'(err_o), 64'd0);
        for (int i = 0; i < 10 && !rd_cmd_valid_o; i++) cyc();
        chk("t6r_in_issue", 64'(rd_cmd_valid_o), 64'd1);
        srst_i = 1'b1;
        cyc();
        srst_i = 1'b0;
        chk("t6r_busy", 64'(busy_o), 64'd0);
        chk("t6r_rem", 64'(rem_o), 64'd0);
        chk("t6r_valids", {62'd0, rd_cmd_valid_o, wr_cmd_valid_o}, 64'd0);
        chk("t6r_addr", rd_cmd_addr_o | wr_cmd_addr_o, 64'd0);
        chk("t6r_flags", {61'd0, err_o, irq_o, done_o}, 64'd0);

        auto_done = 1'b1;
        pending   = 0;
        start_xfer(64'h40, 64'h80, 32'h8);
        wait_done("t6n_done", 40);
        chk("t6n_rd_addr", rd_addr_q[0], 64'h40);
        chk("t6n_wr_addr", wr_addr_q[0], 64'h80);
        chk("t6n_len", 64'(rd_len_q[0]), 64'd1);
        chk("t6n_rem", 64'(rem_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
